// File: rtl/reg_resp_tx.sv
// reg_resp_tx
// Serializes a register readback frame into single bytes for the UART
// transmitter: SYNC_BYTE, ADDR, D[N-1] .. D[0], CHK, where CHK is the XOR of
// ADDR and every data byte. One byte is written per tx_wr_o strobe, and the
// next byte is only offered after the UART reports tx_done_i. A byte whose
// completion does not arrive within TIMEOUT cycles aborts the frame.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   req_valid_i     response request; accepted when req_ready_o is high
//   req_ready_o     high only while idle
//   req_addr_i      register address echoed in the frame
//   req_data_i      register value, DATA_BYTES bytes, sent MSB first
//   tx_done_i       UART pulse: current byte fully shifted out
//   tx_data_o       byte to the UART, stable while tx_wr_o is high
//   tx_wr_o         one-cycle UART write strobe
//   busy_o          frame in progress
//   frame_done_o    one-cycle pulse on successful frame completion
//   err_o           one-cycle pulse when a frame is aborted on timeout
module reg_resp_tx #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         DATA_BYTES = 2,
    parameter int         TIMEOUT    = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [7:0]              req_addr_i,
    input  logic [8*DATA_BYTES-1:0] req_data_i,
    input  logic                    tx_done_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_wr_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    err_o
);

    localparam int LAST_IDX = DATA_BYTES + 2;
    localparam int IW       = $clog2(LAST_IDX + 1);
    localparam int TW       = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              addr_q;
    logic [8*DATA_BYTES-1:0] data_q;
    logic [7:0]              tx_data_q;
    logic [7:0]              chk_q;
    logic [IW-1:0]           idx_q;
    logic [TW-1:0]           tmo_q;
    logic                    frame_done_q;
    logic                    err_q;

    logic                    accept;
    logic                    load_next;
    logic                    finish_ok;
    logic                    abort;
    logic                    last_byte;
    logic                    tmo_hit;
    logic [IW-1:0]           idx_nxt;
    logic [TW-1:0]           tmo_nxt;
    logic [7:0]              nxt_byte;

    // Byte k of the frame. Index 0 (sync) is loaded directly on acceptance;
    // the checksum slot returns the running XOR, which is complete by the
    // time the last data byte has been loaded.
    function automatic logic [7:0] byte_at(
        input logic [IW-1:0]           k,
        input logic [7:0]              addr,
        input logic [8*DATA_BYTES-1:0] data,
        input logic [7:0]              chk
    );
        logic [7:0] b;
        b = 8'h00;
        if (k == '0) begin
            b = SYNC_BYTE;
        end else if (k == IW'(1)) begin
            b = addr;
        end else if (k == IW'(LAST_IDX)) begin
            b = chk;
        end else begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (k == IW'(DATA_BYTES + 1 - i)) begin
                    b = data[8*i +: 8];
                end
            end
        end
        return b;
    endfunction

    assign idx_nxt   = idx_q + IW'(1);
    assign tmo_nxt   = tmo_q + TW'(1);
    assign last_byte = (idx_q == IW'(LAST_IDX));
    // The counter reaches TIMEOUT at the end of the TIMEOUT-th WAIT cycle.
    assign tmo_hit   = (tmo_nxt == TW'(TIMEOUT));
    assign nxt_byte  = byte_at(idx_nxt, addr_q, data_q, chk_q);

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        load_next = 1'b0;
        finish_ok = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the timeout cycle takes priority.
                if (tx_done_i) begin
                    if (last_byte) begin
                        finish_ok = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        load_next = 1'b1;
                        state_d   = SEND;
                    end
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tx_data_q    <= 8'h00;
            chk_q        <= 8'h00;
            idx_q        <= '0;
            tmo_q        <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= finish_ok;
            err_q        <= abort;

            if (accept) begin
                tx_data_q <= SYNC_BYTE;
                idx_q     <= '0;
                chk_q     <= 8'h00;
            end else if (load_next) begin
                tx_data_q <= nxt_byte;
                idx_q     <= idx_nxt;
                if (idx_nxt != IW'(LAST_IDX)) begin
                    chk_q <= chk_q ^ nxt_byte;
                end
            end else if (finish_ok || abort) begin
                tx_data_q <= 8'h00;
                idx_q     <= '0;
                chk_q     <= 8'h00;
            end

            if (state_q == WAIT && state_d == WAIT) begin
                tmo_q <= tmo_nxt;
            end else begin
                tmo_q <= '0;
            end
        end
    end

    // Request capture; the frame in flight only ever reads these copies.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= req_addr_i;
            data_q <= req_data_i;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q == SEND) || (state_q == WAIT);
    assign tx_wr_o      = (state_q == SEND);
    assign tx_data_o    = tx_data_q;
    assign frame_done_o = frame_done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_reg_resp_tx.sv
// Bench for reg_resp_tx: instance A (2 data bytes) and instance B (1 data
// byte), both with a short per-byte timeout of 20 cycles. Expected frames are
// built from the frame definition by a small queue-based model.
module tb_reg_resp_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid_a = 1'b0, req_ready_a;
    logic [7:0]  req_addr_a = 8'h00;
    logic [15:0] req_data_a = 16'h0000;
    logic        tx_done_a = 1'b0;
    logic [7:0]  tx_data_a;
    logic        tx_wr_a, busy_a, frame_done_a, err_a;

    logic        req_valid_b = 1'b0, req_ready_b;
    logic [7:0]  req_addr_b = 8'h00;
    logic [7:0]  req_data_b = 8'h00;
    logic        tx_done_b = 1'b0;
    logic [7:0]  tx_data_b;
    logic        tx_wr_b, busy_b, frame_done_b, err_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       wr;
        logic       fdone;
        logic       err;
        logic [7:0] data;
    } obs_t;

    reg_resp_tx #(.SYNC_BYTE(8'hA5), .DATA_BYTES(2), .TIMEOUT(20)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
        .req_addr_i(req_addr_a), .req_data_i(req_data_a),
        .tx_done_i(tx_done_a), .tx_data_o(tx_data_a), .tx_wr_o(tx_wr_a),
        .busy_o(busy_a), .frame_done_o(frame_done_a), .err_o(err_a)
    );

    reg_resp_tx #(.SYNC_BYTE(8'hA5), .DATA_BYTES(1), .TIMEOUT(20)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
        .req_addr_i(req_addr_b), .req_data_i(req_data_b),
        .tx_done_i(tx_done_b), .tx_data_o(tx_data_b), .tx_wr_o(tx_wr_b),
        .busy_o(busy_b), .frame_done_o(frame_done_b), .err_o(err_b)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t ob(input int w);
        obs_t o;
        if (w == 0) begin
            o.ready = req_ready_a; o.busy = busy_a; o.wr = tx_wr_a;
            o.fdone = frame_done_a; o.err = err_a; o.data = tx_data_a;
        end else begin
            o.ready = req_ready_b; o.busy = busy_b; o.wr = tx_wr_b;
            o.fdone = frame_done_b; o.err = err_b; o.data = tx_data_b;
        end
        return o;
    endfunction

    task automatic drive_req(input int w, input logic v, input logic [7:0] a, input logic [15:0] d);
        if (w == 0) begin
            req_valid_a = v; req_addr_a = a; req_data_a = d;
        end else begin
            req_valid_b = v; req_addr_b = a; req_data_b = d[7:0];
        end
    endtask

    task automatic set_valid(input int w, input logic v);
        if (w == 0) req_valid_a = v; else req_valid_b = v;
    endtask

    task automatic set_done(input int w, input logic v);
        if (w == 0) tx_done_a = v; else tx_done_b = v;
    endtask

    // Reference frame: sync, address, data MSB first, XOR of address and data.
    task automatic model_frame(input int nb, input logic [7:0] a, input logic [15:0] d);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(a);
        x = a;
        for (int i = nb - 1; i >= 0; i--) begin
            exp_q.push_back(d[8*i +: 8]);
            x = x ^ d[8*i +: 8];
        end
        exp_q.push_back(x);
    endtask

    // mode 0: done 5 cycles after each write; 1: random 1..20; 2: exactly 20.
    // Returns in the cycle where frame_done is expected.
    task automatic run_frame(input int w, input logic [7:0] a, input logic [15:0] d,
                             input int mode, input bit scramble);
        obs_t o;
        int   dly;
        model_frame((w == 0) ? 2 : 1, a, d);
        o = ob(w);
        check_eq("ready_before_req", 32'(o.ready), 1);
        drive_req(w, 1'b1, a, d);
        step();
        set_valid(w, 1'b0);
        if (scramble) drive_req(w, 1'b0, 8'($urandom), 16'hDEAD);
        for (int k = 0; k < exp_q.size(); k++) begin
            o = ob(w);
            check_eq($sformatf("tx_wr_byte%0d", k), 32'(o.wr), 1);
            check_eq($sformatf("tx_data_byte%0d", k), 32'(o.data), 32'(exp_q[k]));
            check_eq("busy_in_frame", 32'(o.busy), 1);
            check_eq("ready_in_frame", 32'(o.ready), 0);
            dly = (mode == 0) ? 5 : (mode == 2) ? 20 : int'($urandom_range(1, 20));
            for (int c = 1; c <= dly; c++) begin
                step();
                if (scramble) set_valid(w, 1'($urandom_range(0, 1)));
                o = ob(w);
                if (o.wr !== 1'b0 || o.err !== 1'b0) begin
                    check_eq("wr_err_in_gap", {30'd0, o.wr, o.err}, 0);
                end
            end
            set_valid(w, 1'b0);
            set_done(w, 1'b1);
            step();
            set_done(w, 1'b0);
        end
        o = ob(w);
        check_eq("frame_done_pulse", 32'(o.fdone), 1);
        check_eq("err_at_done", 32'(o.err), 0);
        check_eq("ready_after", 32'(o.ready), 1);
        check_eq("busy_after", 32'(o.busy), 0);
        check_eq("wr_after", 32'(o.wr), 0);
    endtask

    task automatic check_reset_state(input int w, input string tag);
        obs_t o;
        o = ob(w);
        check_eq({tag, "_ready"}, 32'(o.ready), 1);
        check_eq({tag, "_busy"}, 32'(o.busy), 0);
        check_eq({tag, "_wr"}, 32'(o.wr), 0);
        check_eq({tag, "_fdone"}, 32'(o.fdone), 0);
        check_eq({tag, "_err"}, 32'(o.err), 0);
        check_eq({tag, "_data"}, 32'(o.data), 0);
    endtask

    task automatic quiet_cycles(input int w, input int n, input string tag);
        obs_t o;
        for (int c = 0; c < n; c++) begin
            step();
            o = ob(w);
            check_eq({tag, "_wr"}, 32'(o.wr), 0);
            check_eq({tag, "_busy"}, 32'(o.busy), 0);
        end
    endtask

    task automatic timeout_test();
        obs_t o;
        drive_req(0, 1'b1, 8'h5A, 16'hBEEF);
        step();
        set_valid(0, 1'b0);
        o = ob(0);
        check_eq("to_sync", 32'(o.data), 32'h0A5);
        step(); step();
        set_done(0, 1'b1);
        step();
        set_done(0, 1'b0);
        o = ob(0);
        check_eq("to_addr_wr", 32'(o.wr), 1);
        check_eq("to_addr_data", 32'(o.data), 32'h05A);
        for (int c = 1; c <= 20; c++) begin
            step();
            o = ob(0);
            if (o.wr !== 1'b0 || o.err !== 1'b0 || o.busy !== 1'b1) begin
                check_eq($sformatf("to_wait%0d", c), {29'd0, o.wr, o.err, o.busy}, 1);
            end
        end
        step();
        o = ob(0);
        check_eq("to_err_pulse", 32'(o.err), 1);
        check_eq("to_ready", 32'(o.ready), 1);
        check_eq("to_busy", 32'(o.busy), 0);
        check_eq("to_wr", 32'(o.wr), 0);
        check_eq("to_fdone", 32'(o.fdone), 0);
        set_done(0, 1'b1);
        step();
        set_done(0, 1'b0);
        o = ob(0);
        check_eq("to_err_one_cycle", 32'(o.err), 0);
        quiet_cycles(0, 5, "to_late_done");
    endtask

    task automatic reset_mid_frame_test();
        obs_t o;
        drive_req(0, 1'b1, 8'h33, 16'hC0DE);
        step();
        set_valid(0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(); step();
            set_done(0, 1'b1);
            step();
            set_done(0, 1'b0);
        end
        o = ob(0);
        check_eq("rst_msb_data", 32'(o.data), 32'h0C0);
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_state(0, "rst_mid");
        set_done(0, 1'b1);
        step();
        set_done(0, 1'b0);
        o = ob(0);
        check_eq("rst_stray_wr", 32'(o.wr), 0);
        quiet_cycles(0, 4, "rst_quiet");
    endtask

    initial begin
        int gap;
        rst_n = 1'b0;
        step(); step(); step();
        check_reset_state(0, "reset_a");
        check_reset_state(1, "reset_b");
        rst_n = 1'b1;
        step();

        run_frame(0, 8'h12, 16'h3456, 0, 1'b0);
        run_frame(0, 8'hFF, 16'h00FF, 0, 1'b0);
        step();
        check_eq("frame_done_one_cycle", 32'(frame_done_a), 0);

        run_frame(0, 8'hC3, 16'h1234, 1, 1'b1);
        step();
        run_frame(0, 8'($urandom), 16'($urandom), 2, 1'b0);
        step();

        timeout_test();
        reset_mid_frame_test();
        run_frame(0, 8'($urandom), 16'($urandom), 1, 1'b0);

        for (int f = 0; f < 6; f++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                step();
                check_eq("idle_no_fdone", 32'(frame_done_a), 0);
            end
            run_frame(0, 8'($urandom), 16'($urandom), 1, 1'($urandom_range(0, 1)));
        end
        step();

        run_frame(1, 8'h0F, 16'h00F0, 0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            step();
            run_frame(1, 8'($urandom), 16'($urandom), 1, 1'($urandom_range(0, 1)));
        end
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
